// File: rtl/perf_counter_bank.sv
// perf_counter_bank: MMIO-readable bank of edge-counting event counters with a CTRL register.
// Define PERF_COUNTER_SATURATE_EN to make counters saturate at all-ones instead of wrapping.
module perf_counter_bank #(
  parameter int          NUM_CTRS  = 8,
  parameter int          WIDTH     = 16,
  parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_CTRS-1:0] event_in,
  input  logic [15:0]         mem_address,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [15:0]         mem_wdata,
  output logic [15:0]         mem_rdata,
  output logic                mem_resp
);
  typedef enum logic [1:0] {IDLE, RESP, HOLD} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] ctr_q [NUM_CTRS];
  logic [WIDTH-1:0] ctr_d [NUM_CTRS];
  logic [NUM_CTRS-1:0] evt_q, evt_d;
  logic en_q, en_d;
  logic [15:0] rdata_q, rdata_d, rsel, off;
  logic [14:0] idx;
  logic hit, acc, rd_acc, wr_acc, wr_ctrl, clr_all, unused_wdata;

  function automatic logic [WIDTH-1:0] bump(input logic [WIDTH-1:0] v);
`ifdef PERF_COUNTER_SATURATE_EN
    return &v ? v : v + WIDTH'(1);
`else
    return v + WIDTH'(1);
`endif
  endfunction

  assign off          = mem_address - BASE_ADDR;
  assign idx          = off[15:1];
  assign hit          = !off[0] && idx <= 15'(NUM_CTRS);
  assign acc          = state_q == IDLE && (mem_read || mem_write) && hit;
  assign rd_acc       = acc && mem_read;
  assign wr_acc       = acc && !mem_read;
  assign wr_ctrl      = wr_acc && idx == 15'(NUM_CTRS);
  assign clr_all      = wr_ctrl && mem_wdata[1];
  assign unused_wdata = ^mem_wdata[15:2];

  // Clear (single or all) takes priority over a same-cycle increment.
  always_comb begin
    for (int i = 0; i < NUM_CTRS; i++)
      ctr_d[i] = (clr_all || (wr_acc && idx == 15'(i))) ? '0 :
                 (en_q && event_in[i] && !evt_q[i]) ? bump(ctr_q[i]) : ctr_q[i];
    evt_d = event_in;
    en_d  = wr_ctrl ? mem_wdata[0] : en_q;
  end

  always_comb begin
    rsel = idx == 15'(NUM_CTRS) ? {15'b0, en_q} : '0;
    for (int i = 0; i < NUM_CTRS; i++)
      if (idx == 15'(i)) rsel[WIDTH-1:0] = ctr_q[i];
    rdata_d = rd_acc ? rsel : rdata_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = acc ? RESP : IDLE;
      RESP:    state_d = HOLD;
      HOLD:    state_d = (mem_read || mem_write) ? HOLD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_resp  = state_q == RESP;
    mem_rdata = rdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      evt_q   <= '0;
      en_q    <= 1'b1;
      rdata_q <= '0;
      for (int i = 0; i < NUM_CTRS; i++) ctr_q[i] <= '0;
    end else begin
      state_q <= state_d;
      evt_q   <= evt_d;
      en_q    <= en_d;
      rdata_q <= rdata_d;
      for (int i = 0; i < NUM_CTRS; i++) ctr_q[i] <= ctr_d[i];
    end
  end
endmodule

// File: doc/perf_counter_bank.md
PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
- REQ-001: Parameter NUM_CTRS, default 8, number of event counters (1..15).
- REQ-002: Parameter WIDTH, default 16, counter width in bits (1..16).
- REQ-003: Parameter BASE_ADDR, default 16'hFF00, byte address of counter 0; word-aligned.
- REQ-004: clk  input  1  single clock; all state updates on rising edge.
- REQ-005: reset_n  input  1  reset, asynchronous, active-low.
- REQ-006: event_in  input  NUM_CTRS  per-counter level event (stall/miss in progress) from pipeline/caches.
- REQ-007: mem_address  input  16  byte address of the MMIO access.
- REQ-008: mem_read  input  1  read request, held until mem_resp.
- REQ-009: mem_write  input  1  write request, held until mem_resp.
- REQ-010: mem_wdata  input  16  write data.
- REQ-011: mem_rdata  output  16  read data, valid while mem_resp=1.
- REQ-012: mem_resp  output  1  one-cycle completion pulse.

Function
- REQ-013: Address map: counter i at BASE_ADDR+2*i; control register CTRL at BASE_ADDR+2*NUM_CTRS; all other addresses out of range.
- REQ-014: CTRL bit0 = global enable (EN); bit1 = clear-all strobe, write-only, reads 0; bits 15:2 read 0, writes ignored.
- REQ-015: Each event_in bit is edge-detected against a per-bit registered copy; a 0->1 transition while EN=1 increments that counter by 1 in the following cycle; a held level counts once.
- REQ-016: EN=0 freezes all counters; edge registers keep tracking event_in, so a rise during EN=0 is not counted later.
- REQ-017: Handshake FSM states IDLE, RESP, HOLD.
- REQ-018: IDLE -> RESP when (mem_read or mem_write) and address in range; access is decoded and performed on this edge.
- REQ-019: RESP: mem_resp=1 for exactly one cycle; always -> HOLD.
- REQ-020: HOLD -> IDLE when mem_read=0 and mem_write=0; otherwise stay; no second access while request held.
- REQ-021: Latency: mem_resp asserted in the second cycle of a request (one cycle after request seen in IDLE).
- REQ-022: Read of counter i returns its value at the IDLE->RESP edge, zero-extended to 16 bits; read of CTRL returns {15'b0, EN}.
- REQ-023: Write of counter i clears it to 0 regardless of mem_wdata.
- REQ-024: Write of CTRL loads EN=mem_wdata[0]; if mem_wdata[1]=1 all counters clear to 0.
- REQ-025: mem_read and mem_write both high: treated as read, no state change.
- REQ-026: Out-of-range access: FSM stays IDLE, mem_resp stays 0, no state change.
- REQ-027: Clear and increment on same counter in same cycle: clear wins, result 0.
- REQ-028: mem_rdata holds its last value outside RESP.

Reset
- REQ-029: reset_n=0 immediately forces counters=0, EN=1, edge registers=0, FSM=IDLE, mem_resp=0, mem_rdata=0.
- REQ-030: Reset mid-handshake abandons the access; after release a still-held request is taken as new from IDLE.

Configuration
- REQ-031: Macro PERF_COUNTER_SATURATE_EN defined: counter at 2^WIDTH-1 holds on further increment.
- REQ-032: Macro PERF_COUNTER_SATURATE_EN undefined: counter wraps 2^WIDTH-1 -> 0.

Verification
- REQ-033: Reset, read BASE_ADDR+16 (CTRL) -> mem_resp one cycle after request, mem_rdata=16'h0001.
- REQ-034: event_in[2] high 5 cycles then low, repeated 3 times; read BASE_ADDR+4 -> 16'h0003.
- REQ-035: Write CTRL=16'h0000, pulse event_in[0] twice, write CTRL=16'h0001, read counter 0 -> 16'h0000.
- REQ-036: Counter 1 at 16'hFFFF, one event_in[1] rise -> 16'h0000 without macro, 16'hFFFF with PERF_COUNTER_SATURATE_EN.
- REQ-037: Write CTRL=16'h0003 in cycle of event_in[3] rise -> all counters read 0, EN=1.
- REQ-038: mem_read held 6 cycles at BASE_ADDR+2 -> exactly one mem_resp; read at 16'hFE00 -> no mem_resp within 10 cycles.
